debounce3_sync: RTL and testbench

- Upstream input-conditioning stage for the 3-input AND gate.
- Takes three raw, asynchronous switch/pushbutton lines and synchronises each one to clk.
- Debounces each line independently and drives clean levels w, x, y straight into the gate's inputs.
- Also emits one-cycle rise/fall strobes per channel for downstream logging or event counting.

---
 rtl/debounce3_sync_pkg.sv | 21 ++
 rtl/debounce3_sync_if.sv | 21 ++
 rtl/debounce3_sync_ch.sv | 142 ++++++++++++++
 rtl/debounce3_sync.sv | 49 ++++
 tb/tb_debounce3_sync.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/debounce3_sync_pkg.sv
// -----------------------------------------------------------------------------
// debounce3_sync_pkg
//   Shared definitions for the three-channel switch conditioner:
//   - the per-channel debounce FSM state encoding
//   - default synchroniser depth, debounce length and counter width
// -----------------------------------------------------------------------------
package debounce3_sync_pkg;

    // Encoding is fixed: bit 1 is the settled level, bit 0 marks a pending change.
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_e;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/debounce3_sync_if.sv
// -----------------------------------------------------------------------------
// debounce3_sync_if
//   Bundle between the raw switch lines and the conditioned outputs.
//   sw_in : raw asynchronous lines (bit 2 -> w, bit 1 -> x, bit 0 -> y)
//   w,x,y : debounced levels feeding the downstream 3-input AND gate
//   rise  : one-cycle strobe per channel on a debounced 0->1
//   fall  : one-cycle strobe per channel on a debounced 1->0
//   master: drives sw_in, observes the conditioned outputs
//   slave : the conditioner itself
// -----------------------------------------------------------------------------
interface debounce3_sync_if;
    logic [2:0] sw_in;
    logic       w;
    logic       x;
    logic       y;
    logic [2:0] rise;
    logic [2:0] fall;

    modport master (output sw_in, input w, x, y, rise, fall);
    modport slave  (input sw_in, output w, x, y, rise, fall);
endinterface

// File: rtl/debounce3_sync_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
//   One channel of the conditioner: SYNC_STAGES-deep synchroniser, a
//   four-state debounce FSM with a stability counter, and registered
//   rise/fall strobes.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   raw_i  : raw asynchronous switch line
//   db_o   : debounced level (flop output)
//   rise_o : one-cycle pulse coincident with db_o going 0->1
//   fall_o : one-cycle pulse coincident with db_o going 1->0
// -----------------------------------------------------------------------------
module debounce_ch
    import debounce3_sync_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic                   db_q,    db_d;
    logic                   rise_q,  rise_d;
    logic                   fall_q,  fall_d;

    // Plain flop chain; nothing may sit between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end

    assign s = sync_q[SYNC_STAGES-1];

    // State register, including the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state and counter. The entry edge counts as the first stable
    // sample, so the change commits when cnt reaches DEBOUNCE_CYCLES-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            STABLE_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode: level and strobes change only on a committed transition.
    always_comb begin
        db_d   = db_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        case (state_q)
            WAIT_HI: begin
                if (s && cnt_q == CNT_LAST) begin
                    db_d   = 1'b1;
                    rise_d = 1'b1;
                end
            end
            WAIT_LO: begin
                if (!s && cnt_q == CNT_LAST) begin
                    db_d   = 1'b0;
                    fall_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/debounce3_sync.sv
// -----------------------------------------------------------------------------
// debounce3_sync
//   Input conditioner for the 3-input AND gate: three independent
//   synchronise-and-debounce channels.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of debounce3_sync_if
//           sw_in[2]->w, sw_in[1]->x, sw_in[0]->y, rise/fall per bit index
// -----------------------------------------------------------------------------
module debounce3_sync
    import debounce3_sync_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    debounce3_sync_if.slave       bus
);

    localparam int NUM_CH = 3;

    logic [NUM_CH-1:0] db;
    logic [NUM_CH-1:0] rise_w;
    logic [NUM_CH-1:0] fall_w;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw_i  (bus.sw_in[i]),
            .db_o   (db[i]),
            .rise_o (rise_w[i]),
            .fall_o (fall_w[i])
        );
    end

    assign bus.w    = db[2];
    assign bus.x    = db[1];
    assign bus.y    = db[0];
    assign bus.rise = rise_w;
    assign bus.fall = fall_w;

endmodule

// File: tb/tb_debounce3_sync.sv
// -----------------------------------------------------------------------------
// tb_debounce3_sync
//   Directed bench for debounce3_sync with DEBOUNCE_CYCLES=4, SYNC_STAGES=2
//   (clean-step latency: change visible after the 6th sampling edge).
//   Each tick drives inputs on the falling edge and queues the outputs
//   expected after the following rising edge; a checker pops and compares
//   shortly after each rising edge. z models the downstream AND gate.
// -----------------------------------------------------------------------------
module tb_debounce3_sync;

    logic clk;
    logic rst_n;

    debounce3_sync_if bus ();

    debounce3_sync #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Downstream 3-input AND gate.
    logic z;
    assign z = bus.w & bus.x & bus.y;

    int checks = 0;
    int errors = 0;

    // {z, w, x, y, rise[2:0], fall[2:0]}
    logic [9:0] exp_q [$];
    logic [9:0] obs;
    assign obs = {z, bus.w, bus.x, bus.y, bus.rise, bus.fall};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            logic [9:0] e;
            e = exp_q.pop_front();
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL edge_out t=%0t observed z/wxy/rise/fall=%b_%b_%b_%b expected %b_%b_%b_%b",
                       $time, obs[9], obs[8:6], obs[5:3], obs[2:0],
                       e[9], e[8:6], e[5:3], e[2:0]);
            end
        end
    end

    // Drive one sampling edge and queue the outputs expected after it.
    task automatic tick(input logic [2:0] sw, input logic rn, input logic [2:0] lvl,
                        input logic [2:0] r = 3'b000, input logic [2:0] f = 3'b000);
        @(negedge clk);
        bus.sw_in = sw;
        rst_n     = rn;
        exp_q.push_back({&lvl, lvl, r, f});
    endtask

    task automatic hold(input logic [2:0] sw, input int n, input logic [2:0] lvl);
        for (int i = 0; i < n; i++) tick(sw, 1'b1, lvl);
    endtask

    task automatic check_now(input string tag, input logic [9:0] e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, e);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.sw_in = 3'b111;
        #1;
        check_now("reset_no_clock", 10'b0);

        // 1. Reset held with inputs high, then release.
        tick(3'b111, 1'b0, 3'b000);
        tick(3'b111, 1'b0, 3'b000);
        tick(3'b111, 1'b0, 3'b000);
        tick(3'b111, 1'b1, 3'b000);           // edge 0 after release
        hold(3'b111, 4, 3'b000);              // edges 1..4
        tick(3'b111, 1'b1, 3'b111, 3'b111);   // edge 5: all rise
        tick(3'b111, 1'b1, 3'b111);
        hold(3'b000, 5, 3'b111);
        tick(3'b000, 1'b1, 3'b000, 3'b000, 3'b111);
        hold(3'b000, 2, 3'b000);

        // 2. Clean step on y.
        hold(3'b001, 5, 3'b000);
        tick(3'b001, 1'b1, 3'b001, 3'b001);
        hold(3'b001, 2, 3'b001);
        hold(3'b000, 5, 3'b001);
        tick(3'b000, 1'b1, 3'b000, 3'b000, 3'b001);
        hold(3'b000, 2, 3'b000);

        // 3a. Three-edge pulse on x is swallowed.
        hold(3'b010, 3, 3'b000);
        hold(3'b000, 6, 3'b000);

        // 3b. Four-edge pulse on x propagates, then falls.
        hold(3'b010, 4, 3'b000);              // edges 0..3
        tick(3'b000, 1'b1, 3'b000);           // edge 4
        tick(3'b000, 1'b1, 3'b010, 3'b010);   // edge 5: rise
        hold(3'b000, 3, 3'b010);              // edges 6..8
        tick(3'b000, 1'b1, 3'b000, 3'b000, 3'b010); // edge 9: fall
        hold(3'b000, 2, 3'b000);

        // 4. Bounce on w: 1,0,1,1,0,1 then held 1.
        tick(3'b100, 1'b1, 3'b000);
        tick(3'b000, 1'b1, 3'b000);
        tick(3'b100, 1'b1, 3'b000);
        tick(3'b100, 1'b1, 3'b000);
        tick(3'b000, 1'b1, 3'b000);
        hold(3'b100, 5, 3'b000);              // edges 5..9
        tick(3'b100, 1'b1, 3'b100, 3'b100);   // edge 10: single rise
        hold(3'b100, 2, 3'b100);
        hold(3'b000, 5, 3'b100);
        tick(3'b000, 1'b1, 3'b000, 3'b000, 3'b100);
        hold(3'b000, 2, 3'b000);

        // 5. Simultaneous step, gate output follows; drop x.
        hold(3'b111, 5, 3'b000);
        tick(3'b111, 1'b1, 3'b111, 3'b111);
        hold(3'b111, 1, 3'b111);
        hold(3'b101, 5, 3'b111);
        tick(3'b101, 1'b1, 3'b101, 3'b000, 3'b010);
        hold(3'b101, 1, 3'b101);
        hold(3'b000, 5, 3'b101);
        tick(3'b000, 1'b1, 3'b000, 3'b000, 3'b101);
        hold(3'b000, 2, 3'b000);

        // 6. Async reset while y is in WAIT_HI with cnt=2.
        hold(3'b001, 4, 3'b000);              // edges 0..3 -> cnt=2
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_now("mid_reset_async", 10'b0);
        tick(3'b001, 1'b0, 3'b000);
        tick(3'b001, 1'b0, 3'b000);
        tick(3'b001, 1'b1, 3'b000);           // edge 0 after release
        hold(3'b001, 4, 3'b000);              // edges 1..4
        tick(3'b001, 1'b1, 3'b001, 3'b001);   // edge 5
        hold(3'b001, 2, 3'b001);

        @(posedge clk);
        #2;
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain observed %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
